exec_control_unit: RTL

//  Fetch/execute sequencer and 8-entry register file sitting directly downstream of the program ROM.

---
 rtl/exec_control_unit_if.sv | 27 ++
 rtl/exec_control_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/exec_control_unit_if.sv
// Bus between the program ROM / system side and the exec control unit.
// Carries run control, the ROM instruction/immediate, status flags and the debug read port.
interface exec_control_unit_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
);
  logic              run;
  logic [8:0]        instruction;
  logic [DATA_W-1:0] data_var;
  logic              step;
  logic              halted;
  logic              illegal;
  logic              zero;
  logic [CNT_W-1:0]  instr_count;
  logic [2:0]        dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output run, instruction, data_var, dbg_sel,
    input  step, halted, illegal, zero, instr_count, dbg_data
  );

  modport slave (
    input  run, instruction, data_var, dbg_sel,
    output step, halted, illegal, zero, instr_count, dbg_data
  );
endinterface

// File: rtl/exec_control_unit.sv
// Fetch/execute sequencer with an 8-entry register file, fed by the program ROM.
// Build macro SUB_OP_EN turns opcode 101 into subtract; without it, 101 is illegal.
module exec_control_unit #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               resetn,
  exec_control_unit_if.slave bus
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b100;
`ifdef SUB_OP_EN
  localparam logic [2:0] OP_SUB  = 3'b101;
`endif

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    STEP,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    DEC_WRITE,
    DEC_HALT,
    DEC_ILLEGAL
  } dec_t;

  state_t            state_reg, state_next;
  logic [8:0]        ir_reg, ir_next;
  logic [DATA_W-1:0] dr_reg, dr_next;
  logic              step_reg, step_next;
  logic              halted_reg, halted_next;
  logic              illegal_reg, illegal_next;
  logic              zero_reg, zero_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic [2:0]        opcode;
  logic [2:0]        rd;
  logic [2:0]        rs;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] result;
  dec_t              dec_kind;
  logic              reg_we;

  logic [DATA_W-1:0] rf [8];

  assign opcode = ir_reg[8:6];
  assign rd     = ir_reg[5:3];
  assign rs     = ir_reg[2:0];

  // Both operands come from the pre-write register values, so rd==rs cases behave naturally.
  assign op_a = rf[rd];
  assign op_b = rf[rs];

  always_comb begin
    result   = '0;
    dec_kind = DEC_ILLEGAL;
    case (opcode)
      OP_LOAD: begin
        result   = dr_reg;
        dec_kind = DEC_WRITE;
      end
      OP_MOV: begin
        result   = op_b;
        dec_kind = DEC_WRITE;
      end
      OP_ADD: begin
        result   = op_a + op_b;
        dec_kind = DEC_WRITE;
      end
      OP_XOR: begin
        result   = op_a ^ op_b;
        dec_kind = DEC_WRITE;
      end
      OP_HALT: begin
        dec_kind = DEC_HALT;
      end
`ifdef SUB_OP_EN
      OP_SUB: begin
        result   = op_a - op_b;
        dec_kind = DEC_WRITE;
      end
`endif
      default: begin
        dec_kind = DEC_ILLEGAL;
      end
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    ir_next      = ir_reg;
    dr_next      = dr_reg;
    step_next    = 1'b0;
    halted_next  = halted_reg;
    illegal_next = illegal_reg;
    zero_next    = zero_reg;
    count_next   = count_reg;
    reg_we       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.run) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        ir_next    = bus.instruction;
        dr_next    = bus.data_var;
        state_next = EXEC;
      end
      EXEC: begin
        case (dec_kind)
          DEC_WRITE: begin
            reg_we     = 1'b1;
            zero_next  = (result == '0);
            count_next = count_reg + CNT_W'(1);
            step_next  = 1'b1;
            state_next = STEP;
          end
          DEC_HALT: begin
            halted_next = 1'b1;
            state_next  = HALT;
          end
          default: begin
            halted_next  = 1'b1;
            illegal_next = 1'b1;
            state_next   = HALT;
          end
        endcase
      end
      STEP: begin
        state_next = bus.run ? FETCH : IDLE;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      ir_reg      <= '0;
      dr_reg      <= '0;
      step_reg    <= 1'b0;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      zero_reg    <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      ir_reg      <= ir_next;
      dr_reg      <= dr_next;
      step_reg    <= step_next;
      halted_reg  <= halted_next;
      illegal_reg <= illegal_next;
      zero_reg    <= zero_next;
      count_reg   <= count_next;
    end
  end

  // Flop-based register file: the debug port needs an asynchronous read of any entry.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rf
      logic [DATA_W-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (!resetn) begin
          q_reg <= '0;
        end else if (reg_we && (rd == 3'(gi))) begin
          q_reg <= result;
        end
      end

      assign rf[gi] = q_reg;
    end
  endgenerate

  assign bus.step        = step_reg;
  assign bus.halted      = halted_reg;
  assign bus.illegal     = illegal_reg;
  assign bus.zero        = zero_reg;
  assign bus.instr_count = count_reg;
  assign bus.dbg_data    = rf[bus.dbg_sel];

endmodule
